// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and next-PC source encoding for the fetch PC unit.
package pc_pkg;

   localparam int INSN_BYTES = 4;
   localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h4_0000;

   typedef enum logic [2:0] {
      PC_SEQ,
      PC_REL,
      PC_ABS,
      PC_RAS,
      PC_LR,
      PC_HOLD,
      PC_RST
   } pc_src_e;

endpackage

// File: rtl/return_addr_stack.sv
// return_addr_stack: circular return-address stack with saturating count and registered underflow pulse.
module return_addr_stack #(
   parameter int XLEN      = 64,
   parameter int RAS_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [XLEN-1:0]            data_i,
   output logic [XLEN-1:0]            top_o,
   output logic [$clog2(RAS_DEPTH):0] count_o,
   output logic                       underflow_o
);

   localparam int PW = $clog2(RAS_DEPTH);

   logic [XLEN-1:0] mem_q [RAS_DEPTH];
   logic [PW-1:0]   top_q, top_d, wr_ptr;
   logic [PW:0]     count_q, count_d;
   logic            uf_q, uf_d, empty, replace;

   // Pop+push on a non-empty stack rewrites the top in place; all other pushes advance first.
   always_comb begin
      empty   = count_q == '0;
      replace = push_i & pop_i & !empty;
      wr_ptr  = replace ? top_q : top_q + PW'(1);
      top_d   = replace ? top_q : push_i ? top_q + PW'(1) : (pop_i & !empty) ? top_q - PW'(1) : top_q;
      count_d = replace ? count_q
              : push_i ? ((count_q == (PW+1)'(RAS_DEPTH)) ? count_q : count_q + (PW+1)'(1))
              : (pop_i & !empty) ? count_q - (PW+1)'(1) : count_q;
      uf_d    = pop_i & empty;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         top_q   <= '0;
         count_q <= '0;
         uf_q    <= 1'b0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
         uf_q    <= uf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_ptr] <= data_i;
   end

   assign top_o       = mem_q[top_q];
   assign count_o     = count_q;
   assign underflow_o = uf_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC register with sequential, relative, absolute and return-predicted redirects.
module fetch_pc_unit
   import pc_pkg::*;
#(
   parameter int              XLEN         = 64,
   parameter int              OFF_W        = 24,
   parameter int              RAS_DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       stall,
   input  logic                       br_taken,
   input  logic                       br_abs,
   input  logic                       br_link,
   input  logic                       br_ret,
   input  logic [OFF_W-1:0]           br_offset,
   input  logic [XLEN-1:0]            lr_value,
   output logic [XLEN-1:0]            pc,
   output logic [XLEN-1:0]            link_addr,
   output logic [$clog2(RAS_DEPTH):0] ras_count,
   output logic                       ras_underflow
);

   logic [XLEN-1:0] pc_q, pc_d, seq, ext, ras_top;
   logic            ras_push, ras_pop;
   pc_src_e         src;

   assign seq      = pc_q + XLEN'(INSN_BYTES);
   assign ext      = {{(XLEN-OFF_W){br_offset[OFF_W-1]}}, br_offset} << 2;
   assign ras_push = !stall & br_taken & br_link;
   assign ras_pop  = !stall & br_taken & br_ret;

   always_comb begin
      src = rst ? PC_RST : stall ? PC_HOLD : !br_taken ? PC_SEQ
          : br_ret ? (|ras_count ? PC_RAS : PC_LR) : br_abs ? PC_ABS : PC_REL;
      case (src)
         PC_RST:  pc_d = RESET_VECTOR;
         PC_HOLD: pc_d = pc_q;
         PC_RAS:  pc_d = ras_top;
         PC_LR:   pc_d = lr_value & ~XLEN'(3);
         PC_ABS:  pc_d = ext;
         PC_REL:  pc_d = pc_q + ext;
         default: pc_d = seq;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_VECTOR;
      else     pc_q <= pc_d;
   end

   return_addr_stack #(
      .XLEN      (XLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ras_push),
      .pop_i       (ras_pop),
      .data_i      (seq),
      .top_o       (ras_top),
      .count_o     (ras_count),
      .underflow_o (ras_underflow)
   );

   assign pc        = pc_q;
   assign link_addr = seq;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed-vector bench for fetch_pc_unit with hand-computed expectations.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst, stall, br_taken, br_abs, br_link, br_ret;
   logic [23:0] br_offset;
   logic [63:0] lr_value, pc, link_addr;
   logic [2:0]  ras_count;
   logic        ras_underflow;
   int          n_cmp = 0;
   int          n_err = 0;

   fetch_pc_unit dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .br_taken      (br_taken),
      .br_abs        (br_abs),
      .br_link       (br_link),
      .br_ret        (br_ret),
      .br_offset     (br_offset),
      .lr_value      (lr_value),
      .pc            (pc),
      .link_addr     (link_addr),
      .ras_count     (ras_count),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic t, input logic a, input logic l, input logic r, input logic [23:0] off);
      br_taken  = t;
      br_abs    = a;
      br_link   = l;
      br_ret    = r;
      br_offset = off;
   endtask

   task automatic expect_state(input string tag, input logic [63:0] epc, input logic [2:0] ecnt, input logic euf);
      chk({tag, "_pc"}, pc, epc);
      chk({tag, "_cnt"}, 64'(ras_count), 64'(ecnt));
      chk({tag, "_uf"}, 64'(ras_underflow), 64'(euf));
   endtask

   logic [63:0] call_pc [5] = '{64'h400, 64'h500, 64'h600, 64'h700, 64'h800};
   logic [2:0]  call_cnt [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

   initial begin
      rst = 1'b1; stall = 1'b0; lr_value = 64'h1237;
      drive(0, 0, 0, 0, 24'h0);
      tick();
      tick();
      rst = 1'b0;
      expect_state("reset", 64'h40000, 3'd0, 1'b0);
      chk("reset_link", link_addr, 64'h40004);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("seq_pc", pc, 64'h40000 + 64'(4 * i));
      end
      // relative branch backward by 4 words from 0x40010
      drive(1, 0, 0, 0, 24'hFFFFFC);
      tick();
      chk("rel_pc", pc, 64'h40000);
      drive(1, 1, 0, 0, 24'h100);
      tick();
      expect_state("abs", 64'h400, 3'd0, 1'b0);
      // five calls, each relative +0x100 bytes
      for (int i = 0; i < 5; i++) begin
         chk("call_from", pc, call_pc[i]);
         drive(1, 0, 1, 0, 24'h40);
         tick();
         expect_state("call", call_pc[i] + 64'h100, call_cnt[i], 1'b0);
      end
      for (int i = 4; i >= 1; i--) begin
         drive(1, 0, 0, 1, 24'h0);
         tick();
         expect_state("ret", call_pc[i] + 64'h4, 3'(i - 1), 1'b0);
      end
      drive(1, 0, 0, 1, 24'h0);
      tick();
      expect_state("ret_lr", 64'h1234, 3'd0, 1'b1);
      drive(0, 0, 0, 0, 24'h0);
      tick();
      expect_state("after_uf", 64'h1238, 3'd0, 1'b0);
      // return with empty RAS under stall must neither move nor flag underflow
      stall = 1'b1;
      drive(1, 0, 0, 1, 24'h0);
      tick();
      expect_state("stall_ret", 64'h1238, 3'd0, 1'b0);
      stall = 1'b0;
      drive(1, 0, 1, 0, 24'h10);
      tick();
      expect_state("call6", 64'h1278, 3'd1, 1'b0);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_state("stall", 64'h1278, 3'd1, 1'b0);
      end
      stall = 1'b0;
      tick();
      expect_state("unstall", 64'h12B8, 3'd2, 1'b0);
      drive(1, 0, 1, 1, 24'h0);
      tick();
      expect_state("retlink", 64'h127C, 3'd2, 1'b0);
      drive(1, 0, 0, 1, 24'h0);
      tick();
      expect_state("ret_new_top", 64'h12BC, 3'd1, 1'b0);
      tick();
      expect_state("ret_old", 64'h123C, 3'd0, 1'b0);
      drive(1, 0, 1, 0, 24'h4);
      for (int i = 1; i <= 3; i++) begin
         tick();
         expect_state("call3", 64'h123C + 64'(16 * i), 3'(i), 1'b0);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      expect_state("rst_br", 64'h40000, 3'd0, 1'b0);
      drive(1, 1, 0, 0, 24'hFFFFFF);
      tick();
      chk("abs_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("top_link", link_addr, 64'h0);
      drive(0, 0, 0, 0, 24'h0);
      tick();
      chk("wrap", pc, 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
